icache_refill_ctrl: RTL and testbench
=====================================

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 Parameter INDEX_W, default 7, set-index width (128 sets).
REQ-002 Parameter TAG_W, default 20, tag width; offset = 32-INDEX_W-TAG_W = 5 bits (8-word, 32-byte line).
REQ-003 clk  in  1  single clock; all state changes on posedge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 cpu_req  in  1  fetch request valid.
REQ-006 cpu_addr  in  32  fetch address.
REQ-007 cpu_ready  out  1  request accepted this cycle.
REQ-008 resp_valid  out  1  one-cycle pulse: hit resolved for the accepted request.
REQ-009 resp_way  out  1  way holding the line when resp_valid=1.
REQ-010 hit0 / hit1  in  1 each  way 0/1 tag-directory hit, valid one cycle after index/tag are driven.
REQ-011 tagv_index  out  INDEX_W  lookup/write index to both directory ways.
REQ-012 tagv_tag  out  TAG_W  lookup/write tag.
REQ-013 tagv_wen  out  2  per-way directory write enable.
REQ-014 tagv_valid_wdata  out  1  valid bit written; 0 during init, 1 otherwise.
REQ-015 data_wen  out  2  per-way data-RAM word write enable.
REQ-016 data_word  out  3  word offset within the line being written.
REQ-017 data_wdata  out  32  refill word.
REQ-018 mem_req  out  1  line-read request, held until mem_ack.
REQ-019 mem_addr  out  32  line-aligned address {tag, index, 5'b0}.
REQ-020 mem_ack  in  1  request accepted.
REQ-021 mem_rvalid  in  1  read-data beat valid.
REQ-022 mem_rdata  in  32  read-data beat.
REQ-023 mem_rlast  in  1  marks the final (8th) beat.

Function
REQ-024 States: INIT, IDLE, LOOKUP, MISS, REFILL, FINISH.
REQ-025 INIT: 7-bit counter 0..127 drives tagv_index; tagv_wen=2'b11, tagv_valid_wdata=0; after index 127, go to IDLE; cpu_ready=0 throughout.
REQ-026 IDLE: cpu_ready=1; on cpu_req, latch cpu_addr, drive index/tag, go to LOOKUP.
REQ-027 LOOKUP: hit0|hit1 -> resp_valid=1 and resp_way=hit1; LRU[index] := ~resp_way; return to IDLE. Otherwise go to MISS and latch victim = LRU[index].
REQ-028 Both hit0 and hit1 asserted is illegal; resolve to way 1 and flag it with a simulation assertion.
REQ-029 MISS: mem_req=1 with mem_addr line-aligned; on mem_ack, go to REFILL and clear the beat counter.
REQ-030 REFILL: each mem_rvalid writes mem_rdata to data_wen[victim] at data_word = beat counter, then increments the counter; on mem_rvalid&mem_rlast go to FINISH.
REQ-031 mem_rlast arriving with counter != 7 is a protocol error: flag with an assertion and still go to FINISH.
REQ-032 FINISH: tagv_wen[victim]=1, tagv_valid_wdata=1, latched tag/index; LRU[index] := ~victim; go to LOOKUP (re-probe, guaranteed hit, 1 cycle).
REQ-033 Hit latency: request accepted at cycle N -> resp_valid at N+1. Miss latency: N+1 lookup, plus memory time, plus 8 beats, plus FINISH and re-LOOKUP.
REQ-034 cpu_ready=0 in every state except IDLE; tagv_index/tagv_tag hold the latched address outside IDLE/INIT.
REQ-035 LRU: 128x1 register array, cleared to 0 by reset.

Reset
REQ-036 While resetn=0: state=INIT, counters=0, LRU all 0, all outputs 0 (mem_req, cpu_ready, resp_valid, tagv_wen, data_wen included).
REQ-037 Reset asserted mid-REFILL abandons the burst and restarts INIT; beats arriving afterwards are ignored.

Structure
REQ-038 The shared icache package holds the state encoding, LINE_WORDS=8, OFFSET_W=5, and the default INDEX_W/TAG_W.
REQ-039 The block is a single module; LRU array and FSM are inline; no sub-module.

Verification
REQ-040 Reset release -> 128 cycles with tagv_wen=11 and valid_wdata=0, indices 0..127, then cpu_ready=1.
REQ-041 Fetch 0x0000_1040 cold -> miss; mem_addr=0x0000_1040; 8 beats written to way 0, words 0..7; FINISH writes way 0 tag 0x00001; resp_valid with resp_way=0.
REQ-042 Repeat 0x0000_1044 -> resp_valid exactly 1 cycle after acceptance, resp_way=0, no mem_req.
REQ-043 Fetch 0x0000_2040 (same index 2, new tag) -> refill into way 1; then 0x0000_3040 -> victim way 0 (LRU).
REQ-044 Stall mem_ack 10 cycles, then mem_rvalid gaps between beats -> mem_req held, data_word increments only on rvalid.
REQ-045 Assert resetn=0 after 3 refill beats -> outputs zero, INIT restarts, no stale tagv write.

Source files
------------

// File: rtl/icache_refill_ctrl_pkg.sv
// Shared definitions for the instruction-cache refill controller.
// Holds the controller state encoding, the line geometry and the default
// index/tag widths for a 2-way, 128-set, 32-byte-line cache.
package icache_refill_ctrl_pkg;

   localparam int unsigned DEF_INDEX_W = 7;
   localparam int unsigned DEF_TAG_W   = 20;
   localparam int unsigned OFFSET_W    = 5;
   localparam int unsigned LINE_WORDS  = 8;
   localparam int unsigned WORD_W      = $clog2(LINE_WORDS);

   typedef enum logic [2:0] {
      StInit,
      StIdle,
      StLookup,
      StMiss,
      StRefill,
      StFinish
   } state_e;

endpackage

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller (2-way set associative, 1-bit LRU).
// After reset it clears every tag-directory entry, then serves fetch
// requests: one lookup cycle, and on a miss a line read from memory that is
// written beat by beat into the LRU victim way, followed by a directory
// install and a re-probe that produces the response.
//
// Ports:
//   clk, resetn                       clock, async active-low reset
//   cpu_req, cpu_addr, cpu_ready      fetch request handshake
//   resp_valid, resp_way              hit pulse and the way holding the line
//   hit0, hit1                        directory hit, one cycle after lookup
//   tagv_index, tagv_tag, tagv_wen,
//   tagv_valid_wdata                  tag-directory lookup/write port
//   data_wen, data_word, data_wdata   data-RAM word write port
//   mem_req, mem_addr, mem_ack        line-read request handshake
//   mem_rvalid, mem_rdata, mem_rlast  line-read data beats
module icache_refill_ctrl
   import icache_refill_ctrl_pkg::*;
#(
   parameter int unsigned INDEX_W = DEF_INDEX_W,
   parameter int unsigned TAG_W   = DEF_TAG_W
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               cpu_req,
   input  logic [31:0]        cpu_addr,
   output logic               cpu_ready,
   output logic               resp_valid,
   output logic               resp_way,
   input  logic               hit0,
   input  logic               hit1,
   output logic [INDEX_W-1:0] tagv_index,
   output logic [TAG_W-1:0]   tagv_tag,
   output logic [1:0]         tagv_wen,
   output logic               tagv_valid_wdata,
   output logic [1:0]         data_wen,
   output logic [WORD_W-1:0]  data_word,
   output logic [31:0]        data_wdata,
   output logic               mem_req,
   output logic [31:0]        mem_addr,
   input  logic               mem_ack,
   input  logic               mem_rvalid,
   input  logic [31:0]        mem_rdata,
   input  logic               mem_rlast
);

   localparam int unsigned SETS = 1 << INDEX_W;

   state_e              state_q;
   logic [INDEX_W-1:0]  init_cnt_q;
   logic [INDEX_W-1:0]  index_q;
   logic [TAG_W-1:0]    tag_q;
   logic [WORD_W-1:0]   beat_q;
   logic                victim_q;
   logic [SETS-1:0]     lru_q;   // per set: way to replace next

   logic any_hit;
   logic hit_way;
   logic unused_offset;

   assign any_hit       = hit0 | hit1;
   assign hit_way       = hit1;   // a double hit resolves to way 1
   assign unused_offset = ^cpu_addr[OFFSET_W-1:0];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StInit;
         init_cnt_q <= '0;
         index_q    <= '0;
         tag_q      <= '0;
         beat_q     <= '0;
         victim_q   <= 1'b0;
         lru_q      <= '0;
      end else begin
         unique case (state_q)
            StInit: begin
               init_cnt_q <= init_cnt_q + INDEX_W'(1);
               if (&init_cnt_q) state_q <= StIdle;
            end
            StIdle: begin
               if (cpu_req) begin
                  index_q <= cpu_addr[OFFSET_W +: INDEX_W];
                  tag_q   <= cpu_addr[OFFSET_W + INDEX_W +: TAG_W];
                  state_q <= StLookup;
               end
            end
            StLookup: begin
               if (any_hit) begin
                  lru_q[index_q] <= ~hit_way;
                  state_q        <= StIdle;
               end else begin
                  victim_q <= lru_q[index_q];
                  state_q  <= StMiss;
               end
            end
            StMiss: begin
               if (mem_ack) begin
                  beat_q  <= '0;
                  state_q <= StRefill;
               end
            end
            StRefill: begin
               if (mem_rvalid) begin
                  beat_q <= beat_q + WORD_W'(1);
                  // A short burst still completes; the assertion below flags it.
                  if (mem_rlast) state_q <= StFinish;
               end
            end
            StFinish: begin
               lru_q[index_q] <= ~victim_q;
               state_q        <= StLookup;
            end
            default: state_q <= StInit;
         endcase
      end
   end

   // Outputs are decoded from state; everything is forced low while reset is
   // held so nothing leaks out during INIT entry or an abandoned burst.
   always_comb begin
      cpu_ready        = 1'b0;
      resp_valid       = 1'b0;
      resp_way         = 1'b0;
      tagv_index       = '0;
      tagv_tag         = '0;
      tagv_wen         = 2'b00;
      tagv_valid_wdata = 1'b0;
      data_wen         = 2'b00;
      data_word        = '0;
      data_wdata       = '0;
      mem_req          = 1'b0;
      mem_addr         = '0;
      if (resetn) begin
         tagv_index = index_q;
         tagv_tag   = tag_q;
         mem_addr   = {tag_q, index_q, {OFFSET_W{1'b0}}};
         unique case (state_q)
            StInit: begin
               tagv_index = init_cnt_q;
               tagv_tag   = '0;
               tagv_wen   = 2'b11;
            end
            StIdle: begin
               cpu_ready  = 1'b1;
               // Drive the lookup straight from the request so the hit comes
               // back in the very next cycle.
               tagv_index = cpu_addr[OFFSET_W +: INDEX_W];
               tagv_tag   = cpu_addr[OFFSET_W + INDEX_W +: TAG_W];
            end
            StLookup: begin
               resp_valid = any_hit;
               resp_way   = any_hit & hit_way;
            end
            StMiss: begin
               mem_req = 1'b1;
            end
            StRefill: begin
               data_wen[victim_q] = mem_rvalid;
               data_word          = beat_q;
               data_wdata         = mem_rdata;
            end
            StFinish: begin
               tagv_wen[victim_q] = 1'b1;
               tagv_valid_wdata   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   a_dual_hit: assert property (@(posedge clk) disable iff (!resetn)
      (state_q == StLookup) |-> !(hit0 && hit1));

   a_short_burst: assert property (@(posedge clk) disable iff (!resetn)
      (state_q == StRefill && mem_rvalid && mem_rlast) |-> (beat_q == WORD_W'(LINE_WORDS - 1)));

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl. Provides a tag directory and
// data RAM, a memory responder inside the fetch task, and a per-cycle
// checker driven by a set-associative cache model.
module tb_icache_refill_ctrl;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        cpu_req = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic        cpu_ready, resp_valid, resp_way;
   logic        hit0, hit1;
   logic [6:0]  tagv_index;
   logic [19:0] tagv_tag;
   logic [1:0]  tagv_wen;
   logic        tagv_valid_wdata;
   logic [1:0]  data_wen;
   logic [2:0]  data_word;
   logic [31:0] data_wdata;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0, mem_rvalid = 1'b0, mem_rlast = 1'b0;
   logic [31:0] mem_rdata = '0;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   icache_refill_ctrl dut (
      .clk              (clk),
      .resetn           (resetn),
      .cpu_req          (cpu_req),
      .cpu_addr         (cpu_addr),
      .cpu_ready        (cpu_ready),
      .resp_valid       (resp_valid),
      .resp_way         (resp_way),
      .hit0             (hit0),
      .hit1             (hit1),
      .tagv_index       (tagv_index),
      .tagv_tag         (tagv_tag),
      .tagv_wen         (tagv_wen),
      .tagv_valid_wdata (tagv_valid_wdata),
      .data_wen         (data_wen),
      .data_word        (data_word),
      .data_wdata       (data_wdata),
      .mem_req          (mem_req),
      .mem_addr         (mem_addr),
      .mem_ack          (mem_ack),
      .mem_rvalid       (mem_rvalid),
      .mem_rdata        (mem_rdata),
      .mem_rlast        (mem_rlast)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] pat(input logic [31:0] line, input int w);
      return line ^ 32'hC0DE_0000 ^ (32'(w) << 8);
   endfunction

   // Environment: write-first tag directory and data RAM.
   logic        dv   [2][128];
   logic [19:0] dt   [2][128];
   logic [31:0] dram [2][128][8];

   always @(posedge clk) begin
      for (int w = 0; w < 2; w++) begin
         if (tagv_wen[w]) begin
            dv[w][tagv_index] <= tagv_valid_wdata;
            dt[w][tagv_index] <= tagv_tag;
         end
         if (data_wen[w]) dram[w][tagv_index][data_word] <= data_wdata;
      end
      hit0 <= tagv_wen[0] ? tagv_valid_wdata : (dv[0][tagv_index] && dt[0][tagv_index] == tagv_tag);
      hit1 <= tagv_wen[1] ? tagv_valid_wdata : (dv[1][tagv_index] && dt[1][tagv_index] == tagv_tag);
   end

   // Reference model: cache contents, LRU and the progress of the open request.
   typedef enum int {PNone, PWaitHit, PWaitAck, PBeats, PInstall, PReprobe} phase_e;
   bit          mv [2][128];
   logic [19:0] mt [2][128];
   bit          ml [128];

   initial begin
      int          init_k;
      phase_e      ph;
      logic [6:0]  m_idx;
      logic [19:0] m_tag;
      bit          m_hit, m_way;
      int          m_beat;
      init_k = 0;
      ph = PNone;
      m_idx = '0; m_tag = '0; m_hit = 0; m_way = 0; m_beat = 0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            chk("reset_ctl", {cpu_ready, resp_valid, resp_way, tagv_wen, tagv_valid_wdata,
                              data_wen, mem_req}, 0);
            chk("reset_bus", mem_addr | data_wdata | {tagv_tag, tagv_index, data_word}, 0);
            init_k = 0;
            ph = PNone;
            for (int s = 0; s < 128; s++) begin
               mv[0][s] = 0; mv[1][s] = 0; ml[s] = 0;
            end
         end else if (init_k < 128) begin
            chk("init_wen", tagv_wen, 2'b11);
            chk("init_vd", tagv_valid_wdata, 0);
            chk("init_idx", tagv_index, init_k);
            chk("init_quiet", {cpu_ready, resp_valid, mem_req, data_wen}, 0);
            init_k++;
         end else begin
            case (ph)
               PNone: begin
                  chk("idle_ready", cpu_ready, 1);
                  chk("idle_quiet", {resp_valid, mem_req, tagv_wen, data_wen}, 0);
                  if (cpu_req) begin
                     m_idx = cpu_addr[11:5];
                     m_tag = cpu_addr[31:12];
                     chk("look_idx", tagv_index, m_idx);
                     chk("look_tag", tagv_tag, m_tag);
                     m_hit = 0;
                     for (int w = 0; w < 2; w++)
                        if (mv[w][m_idx] && mt[w][m_idx] == m_tag) begin
                           m_hit = 1; m_way = 1'(w);
                        end
                     if (!m_hit) m_way = ml[m_idx];
                     ph = PWaitHit;
                  end
               end
               PWaitHit: begin
                  chk("lk_ready", cpu_ready, 0);
                  chk("lk_addr", {tagv_tag, tagv_index}, {m_tag, m_idx});
                  chk("lk_memreq", mem_req, 0);
                  chk("resp_valid", resp_valid, m_hit);
                  if (m_hit) begin
                     chk("resp_way", resp_way, m_way);
                     ml[m_idx] = ~m_way;
                     ph = PNone;
                  end else begin
                     ph = PWaitAck;
                  end
               end
               PWaitAck: begin
                  chk("mem_req", mem_req, 1);
                  chk("mem_addr", mem_addr, {m_tag, m_idx, 5'b0});
                  chk("miss_quiet", {cpu_ready, resp_valid, tagv_wen, data_wen}, 0);
                  if (mem_ack) begin
                     m_beat = 0;
                     ph = PBeats;
                  end
               end
               PBeats: begin
                  chk("fill_quiet", {mem_req, cpu_ready, resp_valid, tagv_wen}, 0);
                  if (mem_rvalid) begin
                     chk("data_wen", data_wen, 2'b01 << m_way);
                     chk("data_word", data_word, m_beat);
                     chk("data_wdata", data_wdata, mem_rdata);
                     m_beat++;
                     if (mem_rlast) ph = PInstall;
                  end else begin
                     chk("data_idle", data_wen, 0);
                  end
               end
               PInstall: begin
                  chk("fin_wen", tagv_wen, 2'b01 << m_way);
                  chk("fin_vd", tagv_valid_wdata, 1);
                  chk("fin_addr", {tagv_tag, tagv_index}, {m_tag, m_idx});
                  chk("fin_quiet", {cpu_ready, resp_valid, data_wen, mem_req}, 0);
                  mv[m_way][m_idx] = 1;
                  mt[m_way][m_idx] = m_tag;
                  ml[m_idx] = ~m_way;
                  ph = PReprobe;
               end
               PReprobe: begin
                  chk("re_valid", resp_valid, 1);
                  chk("re_way", resp_way, m_way);
                  chk("re_ready", cpu_ready, 0);
                  ph = PNone;
               end
               default: ph = PNone;
            endcase
         end
      end
   end

   // Issue one fetch and act as memory until the response (or abort point).
   task automatic fetch(input logic [31:0] a, input int ack_dly, input int gap_max,
                        input int abort_at, output int lat, output logic way,
                        output int req_cyc, output logic [31:0] maddr);
      int n, dly, beats, t0;
      bit acked, done;
      lat = -1; way = 0; req_cyc = 0; maddr = '0;
      n = 0;
      while (!cpu_ready && n < 300) begin
         @(posedge clk); #1; n++;
      end
      if (!cpu_ready) begin
         chk("ready_timeout", 0, 1);
         return;
      end
      cpu_req = 1'b1; cpu_addr = a; t0 = cyc;
      @(posedge clk); #1;
      cpu_req = 1'b0; cpu_addr = $urandom;
      n = 0; dly = 0; beats = 0; acked = 0; done = 0;
      while (!done && n < 600) begin
         mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rdata = $urandom;
         if (resp_valid) begin
            lat = cyc - t0; way = resp_way; done = 1;
         end else if (mem_req && !acked) begin
            req_cyc++;
            maddr = mem_addr;
            if (dly == ack_dly) begin
               mem_ack = 1'b1; acked = 1;
            end else begin
               dly++;
            end
         end else if (acked && beats < 8) begin
            if (beats == abort_at) begin
               resetn = 1'b0; done = 1;
            end else if ($urandom_range(gap_max, 0) == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata = pat(maddr, beats);
               mem_rlast = (beats == 7);
               beats++;
            end
         end
         if (done) break;
         @(posedge clk); #1; n++;
      end
      if (!done) chk("resp_timeout", 0, 1);
   endtask

   initial begin
      int          lat, rc, n;
      logic        way;
      logic [31:0] ma, a;
      logic [6:0]  idx_pool [3];
      idx_pool[0] = 7'd2; idx_pool[1] = 7'd14; idx_pool[2] = 7'd33;

      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      n = 0;
      while (!cpu_ready && n < 300) begin
         @(posedge clk); #1; n++;
      end
      chk("init_len", n, 128);

      // Cold miss, then hit in the same line.
      fetch(32'h0000_1040, 0, 0, -1, lat, way, rc, ma);
      chk("m1_way", way, 0);
      chk("m1_addr", ma, 32'h0000_1040);
      chk("m1_req", rc, 1);
      for (int w = 0; w < 8; w++) chk("m1_data", dram[0][2][w], pat(32'h0000_1040, w));
      chk("m1_dir", {dv[0][2], dt[0][2]}, {1'b1, 20'h00001});

      fetch(32'h0000_1044, 0, 0, -1, lat, way, rc, ma);
      chk("h1_lat", lat, 1);
      chk("h1_way", way, 0);
      chk("h1_req", rc, 0);

      // Same set, new tags: fill way 1, then evict way 0 by LRU.
      fetch(32'h0000_2040, 1, 1, -1, lat, way, rc, ma);
      chk("m2_way", way, 1);
      chk("m2_addr", ma, 32'h0000_2040);
      fetch(32'h0000_3040, 2, 1, -1, lat, way, rc, ma);
      chk("m3_way", way, 0);
      fetch(32'h0000_2048, 0, 0, -1, lat, way, rc, ma);
      chk("h2_lat", lat, 1);
      chk("h2_way", way, 1);

      // Long ack stall with gapped beats.
      fetch(32'h0000_50a4, 10, 3, -1, lat, way, rc, ma);
      chk("stall_req", rc, 11);
      chk("stall_addr", ma, 32'h0000_50a0);

      // Reset after three beats; stale beats keep arriving.
      fetch(32'h0000_71c0, 0, 0, 3, lat, way, rc, ma);
      chk("abort_noresp", lat, -1);
      repeat (3) begin
         mem_rvalid = 1'b1; mem_rdata = $urandom;
         @(posedge clk); #1;
      end
      resetn = 1'b1;
      n = 0;
      while (!cpu_ready && n < 300) begin
         mem_rvalid = (n < 5); mem_rlast = (n == 4); mem_rdata = $urandom;
         @(posedge clk); #1; n++;
      end
      mem_rvalid = 1'b0; mem_rlast = 1'b0;
      chk("reinit_len", n, 128);
      chk("abort_dir", {dv[0][14], dv[1][14]}, 0);

      fetch(32'h0000_1040, 0, 0, -1, lat, way, rc, ma);
      chk("post_miss", rc, 1);
      chk("post_way", way, 0);

      // Randomized traffic over a few contended sets.
      for (int i = 0; i < 40; i++) begin
         a = {20'($urandom_range(1, 4)), idx_pool[$urandom_range(0, 2)],
              5'($urandom_range(0, 7) * 4)};
         fetch(a, $urandom_range(0, 4), $urandom_range(0, 2), -1, lat, way, rc, ma);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
